// File: rtl/tcp_tx_resp.sv
// tcp_tx_resp: TCP TX request front-end that reserves buffer credit, reports status
// and forwards the payload with a tlast regenerated from the requested length.
module tcp_tx_resp #(
   parameter int BUF_BYTES = 65536
) (
   input  logic         aclk,
   input  logic         areset,
   input  logic         s_tcp_tx_meta_valid,
   output logic         s_tcp_tx_meta_ready,
   input  logic [39:0]  s_tcp_tx_meta_data,
   output logic         m_tcp_tx_stat_valid,
   input  logic         m_tcp_tx_stat_ready,
   output logic [63:0]  m_tcp_tx_stat_data,
   input  logic         s_axis_tcp_tx_tvalid,
   output logic         s_axis_tcp_tx_tready,
   input  logic [511:0] s_axis_tcp_tx_tdata,
   input  logic [63:0]  s_axis_tcp_tx_tkeep,
   input  logic         s_axis_tcp_tx_tlast,
   output logic         m_axis_pkt_tvalid,
   input  logic         m_axis_pkt_tready,
   output logic [511:0] m_axis_pkt_tdata,
   output logic [63:0]  m_axis_pkt_tkeep,
   output logic         m_axis_pkt_tlast,
   input  logic         s_credit_valid,
   input  logic [15:0]  s_credit_bytes,
   output logic [29:0]  m_free_bytes,
   output logic         m_err_proto
);
   typedef enum logic [1:0] {IDLE, STAT, DATA} state_t;
   localparam logic [31:0] BUF = 32'(BUF_BYTES);
   state_t       state_q, state_d;
   logic [15:0]  sid_q, sid_d, len_q, len_d;
   logic [1:0]   err_q, err_d;
   logic [29:0]  space_q, space_d, free_q, free_d;
   logic [10:0]  beat_q, beat_d;
   logic         proto_q, proto_d;
   logic         meta_hs, in_data, last_beat, pkt_hs;
   logic [15:0]  sid_in, len_in, rsv;
   logic [1:0]   err_in;
   logic [31:0]  sum;
   logic [10:0]  exp_beats;
   logic         unused_rsvd;
   assign unused_rsvd = ^s_tcp_tx_meta_data[39:32];
   assign sid_in  = s_tcp_tx_meta_data[15:0];
   assign len_in  = s_tcp_tx_meta_data[31:16];
   assign meta_hs = state_q == IDLE && s_tcp_tx_meta_valid;
   // Empty request outranks an over-size request; both are checked against pre-update credit.
   assign err_in  = len_in == 16'd0 ? 2'd1 : ({14'd0, len_in} > free_q) ? 2'd2 : 2'd0;
   assign rsv     = (meta_hs && err_in == 2'd0) ? len_in : 16'd0;
   assign sum     = {2'd0, free_q} - {16'd0, rsv} + (s_credit_valid ? {16'd0, s_credit_bytes} : 32'd0);
   assign free_d  = sum > BUF ? BUF[29:0] : sum[29:0];
   assign exp_beats = 11'((17'(len_q) + 17'd63) >> 6);
   assign last_beat = beat_q == exp_beats - 11'd1;
   assign in_data   = !areset && state_q == DATA;
   assign pkt_hs    = in_data && s_axis_tcp_tx_tvalid && m_axis_pkt_tready;
   assign s_tcp_tx_meta_ready  = !areset && state_q == IDLE;
   assign m_tcp_tx_stat_valid  = !areset && state_q == STAT;
   assign m_tcp_tx_stat_data   = {err_q, space_q, len_q, sid_q};
   assign s_axis_tcp_tx_tready = in_data && m_axis_pkt_tready;
   assign m_axis_pkt_tvalid    = in_data && s_axis_tcp_tx_tvalid;
   assign m_axis_pkt_tdata     = in_data ? s_axis_tcp_tx_tdata : '0;
   assign m_axis_pkt_tkeep     = in_data ? s_axis_tcp_tx_tkeep : '0;
   assign m_axis_pkt_tlast     = in_data && last_beat;
   assign m_free_bytes = free_q;
   assign m_err_proto  = proto_q;
   always_comb begin
      state_d = state_q;
      sid_d   = sid_q;
      len_d   = len_q;
      err_d   = err_q;
      space_d = space_q;
      beat_d  = beat_q;
      proto_d = proto_q;
      if (meta_hs) begin
         sid_d   = sid_in;
         len_d   = len_in;
         err_d   = err_in;
         space_d = free_q - 30'(rsv);
         state_d = STAT;
      end
      if (state_q == STAT && m_tcp_tx_stat_ready)
         state_d = err_q == 2'd0 ? DATA : IDLE;
      if (pkt_hs) begin
         beat_d  = last_beat ? 11'd0 : beat_q + 11'd1;
         proto_d = proto_q | (s_axis_tcp_tx_tlast != last_beat);
         state_d = last_beat ? IDLE : state_q;
      end
   end
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q <= IDLE;
         sid_q   <= '0;
         len_q   <= '0;
         err_q   <= '0;
         space_q <= '0;
         free_q  <= BUF[29:0];
         beat_q  <= '0;
         proto_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sid_q   <= sid_d;
         len_q   <= len_d;
         err_q   <= err_d;
         space_q <= space_d;
         free_q  <= free_d;
         beat_q  <= beat_d;
         proto_q <= proto_d;
      end
   end
endmodule

// File: tb/tb_tcp_tx_resp.sv
// tb_tcp_tx_resp: directed scoreboard bench for tcp_tx_resp; stimulus queues expected
// stat words and payload beats, a negedge monitor pops them on each output handshake.
module tb_tcp_tx_resp;
   logic         aclk = 1'b0, areset = 1'b1;
   logic         meta_valid = 1'b0, meta_ready;
   logic [39:0]  meta_data = '0;
   logic         stat_valid, stat_ready = 1'b0;
   logic [63:0]  stat_data;
   logic         s_tvalid = 1'b0, s_tready, s_tlast = 1'b0;
   logic [511:0] s_tdata = '0;
   logic [63:0]  s_tkeep = '0;
   logic         p_tvalid, p_tready = 1'b1, p_tlast;
   logic [511:0] p_tdata;
   logic [63:0]  p_tkeep;
   logic         cr_valid = 1'b0;
   logic [15:0]  cr_bytes = '0;
   logic [29:0]  free_bytes;
   logic         err_proto;
   int           vectors = 0, miscompares = 0;
   logic [63:0]  stat_exp_q[$];
   logic [576:0] beat_exp_q[$];

   tcp_tx_resp dut (
      .aclk(aclk), .areset(areset),
      .s_tcp_tx_meta_valid(meta_valid), .s_tcp_tx_meta_ready(meta_ready), .s_tcp_tx_meta_data(meta_data),
      .m_tcp_tx_stat_valid(stat_valid), .m_tcp_tx_stat_ready(stat_ready), .m_tcp_tx_stat_data(stat_data),
      .s_axis_tcp_tx_tvalid(s_tvalid), .s_axis_tcp_tx_tready(s_tready), .s_axis_tcp_tx_tdata(s_tdata),
      .s_axis_tcp_tx_tkeep(s_tkeep), .s_axis_tcp_tx_tlast(s_tlast),
      .m_axis_pkt_tvalid(p_tvalid), .m_axis_pkt_tready(p_tready), .m_axis_pkt_tdata(p_tdata),
      .m_axis_pkt_tkeep(p_tkeep), .m_axis_pkt_tlast(p_tlast),
      .s_credit_valid(cr_valid), .s_credit_bytes(cr_bytes),
      .m_free_bytes(free_bytes), .m_err_proto(err_proto)
   );

   always #5 aclk = ~aclk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] mk(input logic [1:0] e, input logic [29:0] sp, input logic [15:0] l, input logic [15:0] s);
      return {e, sp, l, s};
   endfunction

   always @(negedge aclk) begin : monitor
      logic [576:0] e;
      if (stat_valid && stat_ready) begin
         if (stat_exp_q.size() == 0) check("stat_unexpected", stat_data, 64'd0);
         else check("stat", stat_data, stat_exp_q.pop_front());
      end
      if (p_tvalid && p_tready) begin
         if (beat_exp_q.size() == 0) check("beat_unexpected", {63'd0, p_tlast}, 64'hDEAD);
         else begin
            e = beat_exp_q.pop_front();
            check("beat_tlast", p_tlast, e[576]);
            check("beat_tkeep", p_tkeep, e[575:512]);
            vectors++;
            if (p_tdata !== e[511:0]) begin
               miscompares++;
               $display("FAIL beat_tdata: got %h, wanted %h", p_tdata, e[511:0]);
            end
         end
      end
   end

   task automatic send_meta(input logic [15:0] sid, input logic [15:0] len, input logic cv,
                            input logic [15:0] cb, input logic [63:0] exp, input int hold);
      logic ok;
      logic [63:0] cap;
      ok = 1'b0;
      @(posedge aclk); #1;
      meta_valid = 1'b1; meta_data = {8'hA5, len, sid}; cr_valid = cv; cr_bytes = cb;
      for (int g = 0; g < 20 && !ok; g++) begin
         @(negedge aclk);
         ok = meta_ready;
         if (!ok) begin @(posedge aclk); #1; end
      end
      if (!ok) begin
         check("meta_accept_timeout", 64'd0, 64'd1);
         meta_valid = 1'b0; cr_valid = 1'b0;
         return;
      end
      stat_exp_q.push_back(exp);
      @(posedge aclk); #1;
      meta_valid = 1'b0; cr_valid = 1'b0;
      @(negedge aclk);
      check("stat_latency", stat_valid, 1);
      cap = stat_data;
      for (int h = 0; h < hold; h++) begin
         @(posedge aclk); #1;
         meta_valid = 1'b1;
         @(negedge aclk);
         check("hold_valid", stat_valid, 1);
         check("hold_data", stat_data, cap);
         check("hold_meta_ready", meta_ready, 0);
      end
      @(posedge aclk); #1;
      meta_valid = 1'b0; stat_ready = 1'b1;
      @(posedge aclk); #1;
      stat_ready = 1'b0;
   endtask

   task automatic send_data(input logic [15:0] sid, input int n_send, input int n_total,
                            input int tlast_in, input logic rnd);
      logic hs;
      for (int i = 0; i < n_send; i++) begin
         s_tdata  = {16{sid, 16'(i)}};
         s_tkeep  = {32'hFFFF_FFFF, sid, 16'(i)};
         s_tlast  = i == tlast_in;
         s_tvalid = 1'b1;
         beat_exp_q.push_back({i == n_total - 1, s_tkeep, s_tdata});
         hs = 1'b0;
         for (int g = 0; g < 64 && !hs; g++) begin
            p_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge aclk);
            hs = s_tready && p_tready;
            @(posedge aclk); #1;
         end
         if (!hs) check("beat_timeout", 64'd0, 64'd1);
      end
      s_tvalid = 1'b0; s_tlast = 1'b0; p_tready = 1'b1;
   endtask

   task automatic credit(input logic [15:0] b);
      @(posedge aclk); #1;
      cr_valid = 1'b1; cr_bytes = b;
      @(posedge aclk); #1;
      cr_valid = 1'b0;
   endtask

   task automatic chk_free(input string name, input logic [29:0] exp);
      @(negedge aclk);
      check(name, free_bytes, exp);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      s_tvalid = 1'b1;
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      check("rst_meta_ready", meta_ready, 0);
      check("rst_stat_valid", stat_valid, 0);
      check("rst_s_tready", s_tready, 0);
      check("rst_p_tvalid", p_tvalid, 0);
      check("rst_free", free_bytes, 30'd65536);
      check("rst_err_proto", err_proto, 0);
      @(posedge aclk); #1;
      areset = 1'b0; s_tvalid = 1'b0;
      @(negedge aclk);
      check("idle_meta_ready", meta_ready, 1);
      // basic 130-byte transfer: 3 beats, tlast on the third
      send_meta(16'h0005, 16'd130, 1'b0, 16'd0, mk(2'd0, 30'd65406, 16'd130, 16'h0005), 0);
      send_data(16'h0005, 3, 3, 2, 1'b0);
      chk_free("free_after_130", 30'd65406);
      credit(16'd130);
      chk_free("free_return_130", 30'd65536);
      // empty request
      send_meta(16'h0006, 16'd0, 1'b0, 16'd0, mk(2'd1, 30'd65536, 16'd0, 16'h0006), 0);
      @(negedge aclk);
      check("len0_back_idle", meta_ready, 1);
      check("len0_free", free_bytes, 30'd65536);
      // drain credit down to 100
      send_meta(16'h0007, 16'd65436, 1'b0, 16'd0, mk(2'd0, 30'd100, 16'd65436, 16'h0007), 0);
      send_data(16'h0007, 1023, 1023, 1022, 1'b0);
      chk_free("free_100", 30'd100);
      send_meta(16'h0008, 16'd200, 1'b0, 16'd0, mk(2'd2, 30'd100, 16'd200, 16'h0008), 0);
      chk_free("free_after_err2", 30'd100);
      // return alongside an over-size request: error uses old credit, return still applies
      send_meta(16'h0008, 16'd200, 1'b1, 16'd200, mk(2'd2, 30'd100, 16'd200, 16'h0008), 0);
      chk_free("free_300", 30'd300);
      credit(16'd65535);
      chk_free("free_saturate", 30'd65536);
      // stat backpressure then random downstream backpressure
      send_meta(16'h0009, 16'd192, 1'b0, 16'd0, mk(2'd0, 30'd65344, 16'd192, 16'h0009), 5);
      send_data(16'h0009, 3, 3, 2, 1'b1);
      chk_free("free_after_192", 30'd65344);
      credit(16'd192);
      // framing errors
      send_meta(16'h000A, 16'd64, 1'b0, 16'd0, mk(2'd0, 30'd65472, 16'd64, 16'h000A), 0);
      send_data(16'h000A, 1, 1, 0, 1'b0);
      @(negedge aclk);
      check("proto_clean", err_proto, 0);
      credit(16'd64);
      send_meta(16'h000B, 16'd128, 1'b0, 16'd0, mk(2'd0, 30'd65408, 16'd128, 16'h000B), 0);
      send_data(16'h000B, 2, 2, 0, 1'b0);
      @(negedge aclk);
      check("proto_early_tlast", err_proto, 1);
      credit(16'd128);
      // reset after 1 of 3 beats
      send_meta(16'h0011, 16'd192, 1'b0, 16'd0, mk(2'd0, 30'd65344, 16'd192, 16'h0011), 0);
      send_data(16'h0011, 1, 3, -1, 1'b0);
      areset = 1'b1; s_tvalid = 1'b1;
      @(negedge aclk);
      check("mid_rst_p_tvalid", p_tvalid, 0);
      check("mid_rst_p_tlast", p_tlast, 0);
      check("mid_rst_s_tready", s_tready, 0);
      check("mid_rst_meta_ready", meta_ready, 0);
      @(posedge aclk); #1;
      areset = 1'b0; s_tvalid = 1'b0;
      @(negedge aclk);
      check("post_rst_free", free_bytes, 30'd65536);
      check("post_rst_proto", err_proto, 0);
      check("post_rst_meta_ready", meta_ready, 1);
      send_meta(16'h0012, 16'd64, 1'b0, 16'd0, mk(2'd0, 30'd65472, 16'd64, 16'h0012), 0);
      send_data(16'h0012, 1, 1, 0, 1'b0);
      chk_free("free_final", 30'd65472);
      check("stat_queue_empty", 64'(stat_exp_q.size()), 64'd0);
      check("beat_queue_empty", 64'(beat_exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
